// File: rtl/sm_display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: prescaled tick, 16-phase dwell per digit
// with blank/on/off windows, and a double-buffered frame update committed at frame boundaries.
module sm_display_scan_ctrl #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned BLANK  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_W-1:0]      div_i,
    input  logic [3:0]            bright_i,
    input  logic                  upd_valid_i,
    input  logic [7*DIGITS-1:0]   upd_data_i,
    output logic                  upd_ready_o,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     digit_o,
    output logic                  frame_o
);

    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DATA_W = 7 * DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [4:0] BLANK_PH = 5'(BLANK);

    typedef enum logic [1:0] {ST_BLANK, ST_ON, ST_OFF} state_t;

    logic [DIV_W-1:0]  presc;
    logic [3:0]        phase;
    logic [IDX_W-1:0]  idx;
    state_t            state;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] pending;
    logic              pend_full;

    logic              tick;
    logic              last_phase;
    logic              boundary;
    logic              accept;
    logic              commit;
    logic              full_nxt;
    logic [3:0]        phase_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic [4:0]        on_end;
    state_t            state_nxt;
    logic [6:0]        cur_pat;
    logic [DIGITS-1:0] dig_on;

    // Tick, dwell sequencing and update-buffer decisions for this cycle
    always_comb begin
        tick       = (presc >= div_i);
        last_phase = (phase == 4'd15);
        boundary   = tick && last_phase && (idx == LAST_IDX);
        accept     = upd_valid_i && !pend_full;
        commit     = boundary && pend_full;
        full_nxt   = commit ? 1'b0 : (accept ? 1'b1 : pend_full);
        phase_nxt  = tick ? phase + 4'd1 : phase;
        idx_nxt    = idx;
        if (tick && last_phase) begin
            idx_nxt = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
        // 5-bit window end naturally clamps the ON window at phase 15
        on_end    = BLANK_PH + {1'b0, bright_i};
        state_nxt = ST_OFF;
        if ({1'b0, phase_nxt} < BLANK_PH) begin
            state_nxt = ST_BLANK;
        end else if ({1'b0, phase_nxt} < on_end) begin
            state_nxt = ST_ON;
        end
    end

    // Pattern and active-low select for the digit currently being scanned
    always_comb begin
        cur_pat = '0;
        dig_on  = '1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_pat   = shadow[7*k +: 7];
                dig_on[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            phase       <= '0;
            idx         <= '0;
            state       <= ST_BLANK;
            shadow      <= '0;
            pending     <= '0;
            pend_full   <= 1'b0;
            upd_ready_o <= 1'b1;
            seg_o       <= 7'h7F;
            digit_o     <= '1;
            frame_o     <= 1'b0;
        end else begin
            presc     <= tick ? '0 : presc + DIV_W'(1);
            phase     <= phase_nxt;
            idx       <= idx_nxt;
            state     <= state_nxt;
            pend_full <= full_nxt;
            // A transfer landing on the boundary cycle is held for the next frame
            if (commit) begin
                shadow <= pending;
            end else if (accept) begin
                pending <= upd_data_i;
            end
            upd_ready_o <= !full_nxt;
            frame_o     <= boundary;
            if (state == ST_ON) begin
                seg_o   <= ~cur_pat;
                digit_o <= dig_on;
            end else begin
                seg_o   <= 7'h7F;
                digit_o <= '1;
            end
        end
    end

endmodule

// File: tb/tb_sm_display_scan_ctrl.sv
// Bench for sm_display_scan_ctrl: cycle scoreboard against a behavioural model plus
// scenario tasks for scan timing, handshake, boundary collision, brightness, prescaler and reset.
module tb_sm_display_scan_ctrl;

    localparam int DIGITS = 3;
    localparam int BLANK  = 4;
    localparam logic [20:0] D0 = {7'h06, 7'h5B, 7'h4F};
    localparam logic [20:0] D1 = {7'h07, 7'h3F, 7'h6D};
    localparam logic [20:0] D2 = {7'h7F, 7'h66, 7'h39};
    localparam logic [20:0] D3 = {7'h71, 7'h77, 7'h5E};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] div;
    logic [3:0]  bright;
    logic        valid;
    logic [20:0] data;
    logic        ready;
    logic [6:0]  seg;
    logic [2:0]  digit;
    logic        frame;

    typedef struct packed {
        logic [6:0] seg;
        logic [2:0] dig;
        logic       frame;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int          m_cnt, m_phase, m_idx;
    logic [20:0] m_shadow, m_pend;
    bit          m_full, m_on;

    sm_display_scan_ctrl #(.DIGITS(3), .DIV_W(16), .BLANK(4)) dut (
        .clk(clk), .rst(rst), .div_i(div), .bright_i(bright),
        .upd_valid_i(valid), .upd_data_i(data), .upd_ready_o(ready),
        .seg_o(seg), .digit_o(digit), .frame_o(frame)
    );

    always #5 clk = ~clk;

    // Predict the outputs after the coming edge, advance one clock, compare
    task automatic step();
        exp_t e, x;
        bit   tick, bnd;
        if (rst) begin
            e = '{seg: 7'h7F, dig: 3'b111, frame: 1'b0, ready: 1'b1};
            m_cnt = 0; m_phase = 0; m_idx = 0;
            m_shadow = '0; m_pend = '0; m_full = 0; m_on = 0;
        end else begin
            e.seg   = m_on ? ~m_shadow[m_idx*7 +: 7] : 7'h7F;
            e.dig   = m_on ? ~(3'b001 << m_idx) : 3'b111;
            tick    = (m_cnt >= int'(div));
            bnd     = tick && (m_phase == 15) && (m_idx == DIGITS - 1);
            e.frame = bnd;
            if (bnd && m_full) begin
                m_shadow = m_pend; m_full = 0;
            end else if (valid && !m_full) begin
                m_pend = data; m_full = 1;
            end
            e.ready = !m_full;
            if (tick) begin
                m_cnt = 0;
                if (m_phase == 15) begin
                    m_phase = 0; m_idx = (m_idx + 1) % DIGITS;
                end else begin
                    m_phase++;
                end
            end else begin
                m_cnt++;
            end
            m_on = (m_phase >= BLANK) && (m_phase < BLANK + int'(bright));
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        n_checks++;
        if ({seg, digit, frame, ready} !== x) begin
            n_fail++;
            $display("FAIL scoreboard t=%0t: seg=%h digit=%b frame=%b ready=%b, expected seg=%h digit=%b frame=%b ready=%b",
                     $time, seg, digit, frame, ready, x.seg, x.dig, x.frame, x.ready);
        end
    endtask

    task automatic wait_frame(input int limit, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (frame !== 1'b1 && cycles < limit);
    endtask

    task automatic test_reset();
        rst = 1; div = 0; bright = 8; valid = 0; data = '0;
        step(); step();
        n_checks++;
        if (seg !== 7'h7F || digit !== 3'b111) begin
            n_fail++; $display("FAIL reset_dark: seg=%h digit=%b, expected 7f/111", seg, digit);
        end
        n_checks++;
        if (ready !== 1'b1 || frame !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: ready=%b frame=%b, expected 1/0", ready, frame);
        end
    endtask

    task automatic test_basic_scan();
        int c, dark, frames, frame_at;
        int lit[3];
        int first[3];
        logic [6:0] pat;
        rst = 0; div = 0; bright = 8; valid = 1; data = D0;
        step();
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL basic_accept: ready=%b, expected 0", ready);
        end
        valid = 0;
        wait_frame(200, c);
        n_checks++;
        if (frame !== 1'b1 || c != 47) begin
            n_fail++; $display("FAIL basic_first_frame: frame=%b after %0d cycles, expected 1 after 47", frame, c);
        end
        dark = 0; frames = 0; frame_at = -1;
        for (int k = 0; k < 3; k++) begin lit[k] = 0; first[k] = -1; end
        for (int i = 0; i < 48; i++) begin
            step();
            if (digit === 3'b111 && seg === 7'h7F) dark++;
            for (int k = 0; k < 3; k++) begin
                pat = D0[7*k +: 7];
                if (digit === ~(3'b001 << k) && seg === ~pat) begin
                    lit[k]++;
                    if (first[k] < 0) first[k] = i;
                end
            end
            if (frame === 1'b1) begin frames++; frame_at = i; end
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (lit[k] != 8 || first[k] != 16*k + 4) begin
                n_fail++;
                $display("FAIL basic_digit%0d: lit=%0d first=%0d, expected 8 at %0d", k, lit[k], first[k], 16*k + 4);
            end
        end
        n_checks++;
        if (dark != 24) begin
            n_fail++; $display("FAIL basic_dark: %0d dark cycles, expected 24", dark);
        end
        n_checks++;
        if (frames != 1 || frame_at != 47) begin
            n_fail++; $display("FAIL basic_frame_period: %0d pulses last at %0d, expected 1 at 47", frames, frame_at);
        end
    endtask

    task automatic test_handshake();
        int c, early;
        repeat (20) step();
        valid = 1; data = D1;
        step();
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL hs_accept: ready=%b, expected 0", ready);
        end
        early = 0; c = 0;
        while (frame !== 1'b1 && c < 100) begin
            step(); c++;
            if (frame !== 1'b1 && ready !== 1'b0) early++;
        end
        valid = 0;
        n_checks++;
        if (frame !== 1'b1 || early != 0) begin
            n_fail++; $display("FAIL hs_hold: frame=%b early_ready=%0d, expected 1/0", frame, early);
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL hs_release: ready=%b, expected 1", ready);
        end
        repeat (4) step();
        n_checks++;
        if (digit !== 3'b111) begin
            n_fail++; $display("FAIL hs_blank: digit=%b, expected 111", digit);
        end
        step();
        n_checks++;
        if (digit !== 3'b110 || seg !== ~D1[6:0]) begin
            n_fail++; $display("FAIL hs_commit: digit=%b seg=%h, expected 110/%h", digit, seg, ~D1[6:0]);
        end
    endtask

    task automatic test_collision();
        int c;
        wait_frame(100, c);
        repeat (47) step();
        valid = 1; data = D2;
        step();
        valid = 0;
        n_checks++;
        if (frame !== 1'b1 || ready !== 1'b0) begin
            n_fail++; $display("FAIL col_accept: frame=%b ready=%b, expected 1/0", frame, ready);
        end
        repeat (5) step();
        n_checks++;
        if (digit !== 3'b110 || seg !== ~D1[6:0]) begin
            n_fail++; $display("FAIL col_old_frame: digit=%b seg=%h, expected 110/%h", digit, seg, ~D1[6:0]);
        end
        wait_frame(100, c);
        n_checks++;
        if (frame !== 1'b1 || c != 43 || ready !== 1'b1) begin
            n_fail++; $display("FAIL col_next_boundary: frame=%b cycles=%0d ready=%b, expected 1/43/1", frame, c, ready);
        end
        repeat (5) step();
        n_checks++;
        if (digit !== 3'b110 || seg !== ~D2[6:0]) begin
            n_fail++; $display("FAIL col_commit: digit=%b seg=%h, expected 110/%h", digit, seg, ~D2[6:0]);
        end
    endtask

    task automatic test_brightness();
        int c, lit, lit0, first0, last0;
        bright = 0;
        repeat (2) step();
        lit = 0;
        for (int i = 0; i < 96; i++) begin
            step();
            if (digit !== 3'b111 || seg !== 7'h7F) lit++;
        end
        n_checks++;
        if (lit != 0) begin
            n_fail++; $display("FAIL bright0_dark: %0d lit cycles, expected 0", lit);
        end
        bright = 15;
        repeat (2) step();
        wait_frame(100, c);
        lit = 0; lit0 = 0; first0 = -1; last0 = -1;
        for (int i = 0; i < 48; i++) begin
            step();
            if (digit !== 3'b111) lit++;
            if (digit === 3'b110) begin
                lit0++; last0 = i;
                if (first0 < 0) first0 = i;
            end
        end
        n_checks++;
        if (lit0 != 12 || first0 != 4 || last0 != 15) begin
            n_fail++; $display("FAIL bright15_window: lit=%0d first=%0d last=%0d, expected 12/4/15", lit0, first0, last0);
        end
        n_checks++;
        if (lit != 36) begin
            n_fail++; $display("FAIL bright15_total: %0d lit cycles, expected 36", lit);
        end
    endtask

    task automatic test_prescaler();
        int n, c;
        rst = 1; step();
        rst = 0; div = 9; bright = 8; valid = 0;
        repeat (7) step();
        div = 3;
        n = 0;
        do begin step(); n++; end while (digit === 3'b111 && n < 100);
        n_checks++;
        if (digit !== 3'b110 || seg !== 7'h7F || n != 14) begin
            n_fail++; $display("FAIL presc_first_on: digit=%b seg=%h after %0d cycles, expected 110/7f after 14", digit, seg, n);
        end
        wait_frame(400, c);
        n_checks++;
        if (frame !== 1'b1 || c != 175) begin
            n_fail++; $display("FAIL presc_frame: frame=%b after %0d cycles, expected 1 after 175", frame, c);
        end
        wait_frame(400, c);
        n_checks++;
        if (frame !== 1'b1 || c != 192) begin
            n_fail++; $display("FAIL presc_period: frame=%b after %0d cycles, expected 1 after 192", frame, c);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        rst = 1; step();
        rst = 0; div = 0; bright = 8; valid = 1; data = D0;
        step();
        valid = 0;
        wait_frame(100, c);
        valid = 1; data = D3;
        step();
        valid = 0;
        repeat (40) step();
        n_checks++;
        if (digit !== 3'b011 || seg !== 7'h79 || ready !== 1'b0) begin
            n_fail++; $display("FAIL rmid_setup: digit=%b seg=%h ready=%b, expected 011/79/0", digit, seg, ready);
        end
        rst = 1; step();
        n_checks++;
        if (seg !== 7'h7F || digit !== 3'b111 || ready !== 1'b1 || frame !== 1'b0) begin
            n_fail++; $display("FAIL rmid_reset: seg=%h digit=%b ready=%b frame=%b, expected 7f/111/1/0", seg, digit, ready, frame);
        end
        step();
        rst = 0;
        repeat (5) step();
        n_checks++;
        if (digit !== 3'b110 || seg !== 7'h7F || ready !== 1'b1) begin
            n_fail++; $display("FAIL rmid_restart: digit=%b seg=%h ready=%b, expected 110/7f/1", digit, seg, ready);
        end
        wait_frame(100, c);
        n_checks++;
        if (frame !== 1'b1 || c != 43 || ready !== 1'b1) begin
            n_fail++; $display("FAIL rmid_frame: frame=%b cycles=%0d ready=%b, expected 1/43/1", frame, c, ready);
        end
        repeat (5) step();
        n_checks++;
        if (digit !== 3'b110 || seg !== 7'h7F) begin
            n_fail++; $display("FAIL rmid_discard: digit=%b seg=%h, expected 110/7f", digit, seg);
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_handshake();
        test_collision();
        test_brightness();
        test_prescaler();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
